// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan controller.
//   NUM_DIGITS   - digits on the display (one hex nibble each)
//   SEG_BLANK    - active-low pattern with every segment dark
//   HEX_0..HEX_F - active-low {g,f,e,d,c,b,a} glyphs for the hex digits
//   load_state_t - states of the load/commit handshake
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } load_state_t;

endpackage

// File: rtl/seg_hex7.sv
// seg_hex7: combinational hex nibble to seven-segment glyph decoder.
//   nibble - 4-bit value to display
//   seg_n  - active-low segments {g,f,e,d,c,b,a}
module seg_hex7
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (nibble)
            4'h0: seg_n = HEX_0;
            4'h1: seg_n = HEX_1;
            4'h2: seg_n = HEX_2;
            4'h3: seg_n = HEX_3;
            4'h4: seg_n = HEX_4;
            4'h5: seg_n = HEX_5;
            4'h6: seg_n = HEX_6;
            4'h7: seg_n = HEX_7;
            4'h8: seg_n = HEX_8;
            4'h9: seg_n = HEX_9;
            4'hA: seg_n = HEX_A;
            4'hB: seg_n = HEX_B;
            4'hC: seg_n = HEX_C;
            4'hD: seg_n = HEX_D;
            4'hE: seg_n = HEX_E;
            4'hF: seg_n = HEX_F;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit
// common-anode seven-segment display.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - single-cycle request to display data_in/dp_in
//   data_in     - 32-bit hex value, nibble k shown on digit k
//   dp_in       - decimal points, 1 = lit
//   lz_en       - leading-zero blanking enable (level)
//   Q           - current digit index, feeds the digit-enable decoder
//   seg_n, dp_n - active-low segments / decimal point for digit Q
//   load_ack    - one-cycle pulse after new data has been committed
//   frame_start - one-cycle pulse in the first cycle with Q == 0
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned GUARD    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        lz_en,
    output logic [2:0]  Q,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        load_ack,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [2:0]       q_nxt;
    logic             tick;
    logic             boundary;

    load_state_t      state;
    load_state_t      state_nxt;
    logic [31:0]      pend_data;
    logic [31:0]      pend_data_nxt;
    logic [7:0]       pend_dp;
    logic [7:0]       pend_dp_nxt;
    logic [31:0]      act_data;
    logic [31:0]      act_data_nxt;
    logic [7:0]       act_dp;
    logic [7:0]       act_dp_nxt;
    logic             commit;

    logic [7:0]       lz_blank;
    logic             seen_nz;
    logic [3:0]       nibble;
    logic [6:0]       hex_pat;
    logic             in_guard;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;

    // Prescaler and digit index.
    always_comb begin
        tick      = (count == CNT_MAX);
        boundary  = tick && (Q == 3'd7);
        count_nxt = tick ? '0 : count + 1'b1;
        q_nxt     = tick ? Q + 3'd1 : Q;
    end

    // Load FSM. A load coinciding with a frame boundary bypasses the
    // pending register and goes straight to active, so it is never
    // delayed by a frame and supersedes anything already pending.
    always_comb begin
        state_nxt     = state;
        pend_data_nxt = pend_data;
        pend_dp_nxt   = pend_dp;
        act_data_nxt  = act_data;
        act_dp_nxt    = act_dp;
        commit        = 1'b0;
        if (boundary && load) begin
            act_data_nxt = data_in;
            act_dp_nxt   = dp_in;
            commit       = 1'b1;
            state_nxt    = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (load) begin
                        pend_data_nxt = data_in;
                        pend_dp_nxt   = dp_in;
                        state_nxt     = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (boundary) begin
                        act_data_nxt = pend_data;
                        act_dp_nxt   = pend_dp;
                        commit       = 1'b1;
                        state_nxt    = ST_EMPTY;
                    end else if (load) begin
                        pend_data_nxt = data_in;
                        pend_dp_nxt   = dp_in;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Leading-zero mask on the data that will be shown next cycle.
    // Digit k is blankable when nibbles 7..k are all zero; digit 0 never is.
    always_comb begin
        lz_blank = '0;
        seen_nz  = 1'b0;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            seen_nz     = seen_nz | (act_data_nxt[4*k +: 4] != 4'h0);
            lz_blank[k] = ~seen_nz;
        end
    end

    assign nibble = act_data_nxt[{q_nxt, 2'b00} +: 4];

    seg_hex7 u_hex (
        .nibble (nibble),
        .seg_n  (hex_pat)
    );

    // Outputs are computed from next-state values so the registered
    // segment lines always match the registered Q.
    always_comb begin
        in_guard = (GUARD != 0) && (count_nxt < GUARD_C);
        seg_nxt  = SEG_BLANK;
        dp_nxt   = 1'b1;
        if (!in_guard) begin
            seg_nxt = (lz_en && lz_blank[q_nxt]) ? SEG_BLANK : hex_pat;
            dp_nxt  = ~act_dp_nxt[q_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            Q           <= '0;
            state       <= ST_EMPTY;
            pend_data   <= '0;
            pend_dp     <= '0;
            act_data    <= '0;
            act_dp      <= '0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            count       <= count_nxt;
            Q           <= q_nxt;
            state       <= state_nxt;
            pend_data   <= pend_data_nxt;
            pend_dp     <= pend_dp_nxt;
            act_data    <= act_data_nxt;
            act_dp      <= act_dp_nxt;
            seg_n       <= seg_nxt;
            dp_n        <= dp_nxt;
            load_ack    <= commit;
            frame_start <= boundary;
        end
    end

endmodule
